// File: rtl/tart_acquire.sv
// Antenna sample acquisition: tapped input history, optional LFSR test data,
// a small FIFO and a sequential writer toward the memory controller port.
module tart_acquire #(
    parameter int AXNUM = 24,
    parameter int ABITS = 20,
    parameter int BBITS = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [AXNUM-1:0] ax_data_i,
    input  logic             ax_stb_i,
    input  logic [2:0]       aq_delay_i,
    input  logic             aq_debug_i,
    input  logic             aq_ce_i,
    input  logic             rd_req_i,
    output logic             mcb_ce_o,
    output logic             mcb_wr_o,
    output logic [31:0]      mcb_dat_o,
    output logic [ABITS-1:0] mcb_adr_o,
    input  logic             mcb_rdy_i,
    output logic [AXNUM-1:0] ax_data_o,
    output logic             aq_done_o,
    output logic             aq_ovf_o,
    output logic [2:0]       tart_state
);

    // state    | meaning
    // IDLE     | waiting for aq_ce_i
    // CAPTURE  | strobes push samples, FIFO drains to memory
    // DRAIN    | no pushes, remaining FIFO entries written out
    // DONE     | block complete, waiting for host rd_req_i
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [BBITS:0] DEPTH     = {1'b1, {BBITS{1'b0}}};
    localparam logic [31:0]    LFSR_SEED = 32'hACE1_0001;
    localparam logic [31:0]    LFSR_MASK = 32'h8020_0003;

    state_t r_state, w_next;

    logic [AXNUM-1:0] r_hist [8];
    logic [AXNUM-1:0] r_mem [2**BBITS];
    logic [BBITS-1:0] r_wr_ptr, r_rd_ptr;
    logic [BBITS:0]   r_count;
    logic [ABITS:0]   r_pcnt;
    logic [ABITS-1:0] r_adr;
    logic [31:0]      r_lfsr;
    logic             r_ovf;
    logic [AXNUM-1:0] r_ax_data;

    logic [AXNUM-1:0] w_sample;
    logic [31:0]      w_lfsr_next;
    logic w_empty, w_full, w_ce, w_pop, w_push_try, w_push, w_ovf, w_start;

    assign w_sample    = aq_debug_i ? r_lfsr[AXNUM-1:0] : r_hist[aq_delay_i];
    assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_MASK : 32'h0);

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == DEPTH);
    assign w_ce       = ((r_state == ST_CAPTURE) || (r_state == ST_DRAIN)) && !w_empty;
    assign w_pop      = w_ce && mcb_rdy_i;
    // r_pcnt MSB set means the whole address space has been filled once
    assign w_push_try = ax_stb_i && (r_state == ST_CAPTURE) && !r_pcnt[ABITS];
    assign w_push     = w_push_try && (!w_full || w_pop);
    assign w_ovf      = w_push_try && w_full && !w_pop;
    assign w_start    = (r_state == ST_IDLE) && aq_ce_i;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (aq_ce_i) w_next = ST_CAPTURE;
            ST_CAPTURE: if (!aq_ce_i || r_pcnt[ABITS]) w_next = ST_DRAIN;
            ST_DRAIN:   if (w_empty) w_next = ST_DONE;
            ST_DONE:    if (rd_req_i) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pcnt    <= '0;
            r_adr     <= '0;
            r_lfsr    <= LFSR_SEED;
            r_ovf     <= 1'b0;
            r_ax_data <= '0;
            for (int i = 0; i < 8; i++) r_hist[i] <= '0;
        end else begin
            r_state   <= w_next;
            r_hist[0] <= ax_data_i;
            for (int i = 1; i < 8; i++) r_hist[i] <= r_hist[i-1];
            if (ax_stb_i) begin
                r_ax_data <= w_sample;
                r_lfsr    <= w_lfsr_next;
            end
            if (w_start) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_pcnt   <= '0;
                r_adr    <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_pcnt   <= r_pcnt + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_adr    <= r_adr + 1'b1;
                end
                if (w_push && !w_pop)      r_count <= r_count + 1'b1;
                else if (!w_push && w_pop) r_count <= r_count - 1'b1;
                if (w_ovf) r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) r_mem[r_wr_ptr] <= w_sample;
    end

    assign mcb_ce_o   = w_ce;
    assign mcb_wr_o   = w_ce;
    assign mcb_dat_o  = w_ce ? 32'(r_mem[r_rd_ptr]) : 32'd0;
    assign mcb_adr_o  = r_adr;
    assign ax_data_o  = r_ax_data;
    assign aq_done_o  = (r_state == ST_DONE);
    assign aq_ovf_o   = r_ovf;
    assign tart_state = {1'b0, r_state};

endmodule

// File: tb/tb_tart_acquire.sv
// Bench for tart_acquire (AXNUM=24, ABITS=4, BBITS=2): cycle-level queue model
// checked every cycle, plus directed scenarios and a randomized phase.
module tb_tart_acquire;

    localparam int AXNUM  = 24;
    localparam int ABITS  = 4;
    localparam int BBITS  = 2;
    localparam int NADR   = 16;
    localparam int FDEPTH = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [AXNUM-1:0] ax_data_i = '0;
    logic             ax_stb_i = 1'b0;
    logic [2:0]       aq_delay_i = '0;
    logic             aq_debug_i = 1'b0;
    logic             aq_ce_i = 1'b0;
    logic             rd_req_i = 1'b0;
    logic             mcb_ce_o, mcb_wr_o;
    logic [31:0]      mcb_dat_o;
    logic [ABITS-1:0] mcb_adr_o;
    logic             mcb_rdy_i = 1'b0;
    logic [AXNUM-1:0] ax_data_o;
    logic             aq_done_o, aq_ovf_o;
    logic [2:0]       tart_state;

    tart_acquire #(.AXNUM(AXNUM), .ABITS(ABITS), .BBITS(BBITS)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ax_data_i(ax_data_i), .ax_stb_i(ax_stb_i),
        .aq_delay_i(aq_delay_i), .aq_debug_i(aq_debug_i), .aq_ce_i(aq_ce_i),
        .rd_req_i(rd_req_i), .mcb_ce_o(mcb_ce_o), .mcb_wr_o(mcb_wr_o),
        .mcb_dat_o(mcb_dat_o), .mcb_adr_o(mcb_adr_o), .mcb_rdy_i(mcb_rdy_i),
        .ax_data_o(ax_data_o), .aq_done_o(aq_done_o), .aq_ovf_o(aq_ovf_o),
        .tart_state(tart_state)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // reference model state
    bit               m_valid = 0;
    int               m_state = 0;
    logic [AXNUM-1:0] m_q[$];
    int               m_adr = 0;
    int               m_pushed = 0;
    bit               m_ovf = 0;
    logic [31:0]      m_lfsr = 32'hACE1_0001;
    logic [AXNUM-1:0] m_hist [8];
    logic [AXNUM-1:0] m_axo = '0;

    int               n_wr = 0;
    logic [ABITS-1:0] wr_adr[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // x^32 + x^22 + x^2 + x + 1, shifting toward bit 0
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        logic fb;
        fb = v[0];
        v  = v >> 1;
        if (fb) v = v ^ 32'h8020_0003;
        return v;
    endfunction

    task automatic model_edge();
        logic [AXNUM-1:0] samp;
        bit ce_exp, pop;
        int nstate;
        if (rst_i) begin
            m_state = 0; m_q.delete(); m_adr = 0; m_pushed = 0; m_ovf = 0;
            m_lfsr = 32'hACE1_0001; m_axo = '0;
            for (int i = 0; i < 8; i++) m_hist[i] = '0;
            return;
        end
        samp   = aq_debug_i ? m_lfsr[AXNUM-1:0] : m_hist[aq_delay_i];
        ce_exp = (m_state == 1 || m_state == 2) && m_q.size() != 0;
        pop    = ce_exp && mcb_rdy_i;
        nstate = m_state;
        case (m_state)
            0: if (aq_ce_i) begin
                   nstate = 1; m_q.delete(); m_adr = 0; m_pushed = 0; m_ovf = 0;
               end
            1: if (!aq_ce_i || m_pushed == NADR) nstate = 2;
            2: if (m_q.size() == 0) nstate = 3;
            3: if (rd_req_i) nstate = 0;
            default: nstate = 0;
        endcase
        if (pop) begin
            void'(m_q.pop_front());
            m_adr = (m_adr + 1) % NADR;
        end
        if (m_state == 1 && ax_stb_i && m_pushed < NADR) begin
            if (m_q.size() < FDEPTH) begin
                m_q.push_back(samp);
                m_pushed++;
            end else m_ovf = 1;
        end
        if (ax_stb_i) begin
            m_axo  = samp;
            m_lfsr = lfsr_next(m_lfsr);
        end
        for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = ax_data_i;
        m_state = nstate;
    endtask

    // One clock: compare outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit ce_exp;
        @(negedge clk_i);
        if (m_valid) begin
            ce_exp = (m_state == 1 || m_state == 2) && m_q.size() != 0;
            chk("state", 32'(tart_state), m_state);
            chk("mcb_ce", 32'(mcb_ce_o), 32'(ce_exp));
            chk("mcb_wr", 32'(mcb_wr_o), 32'(ce_exp));
            chk("mcb_adr", 32'(mcb_adr_o), m_adr);
            chk("mcb_dat", mcb_dat_o, ce_exp ? 32'(m_q[0]) : 32'h0);
            chk("done", 32'(aq_done_o), 32'(m_state == 3));
            chk("ovf", 32'(aq_ovf_o), 32'(m_ovf));
            chk("ax_data_o", 32'(ax_data_o), 32'(m_axo));
        end
        if (mcb_ce_o === 1'b1 && mcb_rdy_i) begin
            n_wr++;
            wr_adr.push_back(mcb_adr_o);
        end
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; ax_stb_i = 0; aq_ce_i = 0; rd_req_i = 0; mcb_rdy_i = 0;
        aq_debug_i = 0; aq_delay_i = 0; ax_data_i = '0;
        step();
        rst_i = 1'b0;
        m_valid = 1;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 80; i++) begin
            if (aq_done_o === 1'b1) break;
            step();
        end
        chk(tag, 32'(aq_done_o), 32'd1);
    endtask

    initial begin
        logic [31:0] lv;

        do_reset();
        chk("rst_state", 32'(tart_state), 32'd0);
        chk("rst_ce", 32'(mcb_ce_o), 32'd0);
        chk("rst_axo", 32'(ax_data_o), 32'd0);

        // full address space: 16 strobes, writes to 0..15, DRAIN then DONE
        aq_ce_i = 1; mcb_rdy_i = 1; step();
        n_wr = 0; wr_adr.delete();
        ax_stb_i = 1;
        for (int i = 0; i < NADR; i++) begin
            ax_data_i = AXNUM'($urandom);
            step();
        end
        ax_stb_i = 0;
        wait_done("blk_done");
        chk("blk_nwr", n_wr, NADR);
        for (int i = 0; i < NADR && i < wr_adr.size(); i++)
            chk("blk_adr", 32'(wr_adr[i]), i);
        aq_ce_i = 0; rd_req_i = 1; step(); rd_req_i = 0;
        chk("blk_idle", 32'(tart_state), 32'd0);

        // overflow: memory stalled, six strobes into a four-deep FIFO
        do_reset();
        ax_data_i = 24'h111111; aq_ce_i = 1; step();
        ax_stb_i = 1;
        for (int i = 0; i < 6; i++) begin
            ax_data_i = 24'h222222 + AXNUM'(i);
            step();
        end
        ax_stb_i = 0; step();
        chk("ovf_flag", 32'(aq_ovf_o), 32'd1);
        chk("ovf_head", mcb_dat_o, 32'h0011_1111);
        n_wr = 0; aq_ce_i = 0; mcb_rdy_i = 1;
        wait_done("ovf_done");
        chk("ovf_nwr", n_wr, FDEPTH);

        // tap delay: one-cycle pulse, strobe with gap 4, 5 and 6
        do_reset();
        for (int g = 4; g <= 6; g++) begin
            aq_delay_i = 3'd5; ax_data_i = '0;
            repeat (8) step();
            ax_data_i = 24'hA5A5A5; step();
            ax_data_i = '0;
            repeat (g) step();
            ax_stb_i = 1; step(); ax_stb_i = 0;
            chk("tap", 32'(ax_data_o), (g == 5) ? 32'h00A5A5A5 : 32'h0);
        end

        // debug LFSR data from seed
        do_reset();
        aq_debug_i = 1; lv = 32'hACE1_0001;
        for (int i = 0; i < 3; i++) begin
            ax_stb_i = 1; step(); ax_stb_i = 0; step();
            chk("lfsr", 32'(ax_data_o), {8'h0, lv[23:0]});
            lv = lfsr_next(lv);
        end
        aq_debug_i = 0;

        // enable dropped with three entries queued, acceptance toggling
        do_reset();
        aq_ce_i = 1; step();
        ax_stb_i = 1; repeat (3) step();
        ax_stb_i = 0; aq_ce_i = 0;
        n_wr = 0;
        for (int i = 0; i < 40; i++) begin
            if (aq_done_o === 1'b1) break;
            mcb_rdy_i = ~mcb_rdy_i;
            step();
        end
        chk("drop_done", 32'(aq_done_o), 32'd1);
        chk("drop_nwr", n_wr, 3);

        // reset while a write is pending
        do_reset();
        aq_ce_i = 1; step();
        ax_stb_i = 1; ax_data_i = 24'h5A5A5A; step(); step(); ax_stb_i = 0;
        chk("pre_rst_ce", 32'(mcb_ce_o), 32'd1);
        rst_i = 1; step(); rst_i = 0; aq_ce_i = 0;
        chk("rst_mid_state", 32'(tart_state), 32'd0);
        chk("rst_mid_ce", 32'(mcb_ce_o), 32'd0);
        chk("rst_mid_wr", 32'(mcb_wr_o), 32'd0);
        chk("rst_mid_dat", mcb_dat_o, 32'd0);
        chk("rst_mid_adr", 32'(mcb_adr_o), 32'd0);
        chk("rst_mid_axo", 32'(ax_data_o), 32'd0);
        chk("rst_mid_flags", {30'd0, aq_done_o, aq_ovf_o}, 32'd0);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            ax_data_i  = AXNUM'($urandom);
            ax_stb_i   = ($urandom_range(0, 2) != 0);
            mcb_rdy_i  = ($urandom_range(0, 3) != 0) ^ (i[7] == 1'b1);
            aq_ce_i    = ($urandom_range(0, 15) != 0);
            rd_req_i   = ($urandom_range(0, 3) == 0);
            aq_delay_i = 3'($urandom_range(0, 7));
            aq_debug_i = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tart_acquire.md
TART_ACQUIRE -- requirements
Module: tart_acquire

Interface
REQ-001 SHALL have parameter AXNUM, default 24, antenna channel count (1..32).
REQ-002 SHALL have parameter ABITS, default 20, MCB word-address width.
REQ-003 SHALL have parameter BBITS, default 4, log2 of internal FIFO depth.
REQ-004 SHALL have port clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port ax_data_i  in  AXNUM  raw antenna bits.
REQ-007 SHALL have port ax_stb_i  in  1  sample strobe, at most one per clk_i.
REQ-008 SHALL have port aq_delay_i  in  3  sample tap select, 0..7 clk_i cycles.
REQ-009 SHALL have port aq_debug_i  in  1  1 = use internal LFSR data.
REQ-010 SHALL have port aq_ce_i  in  1  acquisition enable.
REQ-011 SHALL have port rd_req_i  in  1  host read complete; re-arms block.
REQ-012 SHALL have ports mcb_ce_o/mcb_wr_o  out  1 each  write request, mcb_dat_o  out  32, mcb_adr_o  out  ABITS, and mcb_rdy_i  in  1  accept.
REQ-013 SHALL have port ax_data_o  out  AXNUM  last captured sample.
REQ-014 SHALL have ports aq_done_o, aq_ovf_o  out  1 each, and tart_state  out  3  state code.

Function
REQ-015 SHALL register ax_data_i every cycle into an 8-stage history h[0..7], h[0] newest.
REQ-016 On ax_stb_i, sample SHALL be h[aq_delay_i] (aq_debug_i=0) or LFSR value (aq_debug_i=1); ax_data_o updates the next cycle.
REQ-017 LFSR SHALL be 32-bit Galois, taps 32,22,2,1, seed 32'hACE1_0001, advance once per ax_stb_i; sample = low AXNUM bits.
REQ-018 States SHALL be IDLE(0), CAPTURE(1), DRAIN(2), DONE(3); tart_state = code.
REQ-019 IDLE -> CAPTURE when aq_ce_i=1; on entry clear address, FIFO and aq_ovf_o.
REQ-020 In CAPTURE each strobe SHALL push zero-extended 32-bit sample into FIFO unless full.
REQ-021 Strobe with FIFO full SHALL drop the sample and set sticky aq_ovf_o.
REQ-022 CAPTURE -> DRAIN when aq_ce_i=0 or when 2^ABITS samples have been pushed; no pushes in DRAIN.
REQ-023 DRAIN -> DONE when FIFO empty and no MCB write pending.
REQ-024 DONE -> IDLE on rd_req_i=1; aq_done_o=1 only in DONE.
REQ-025 mcb_ce_o=mcb_wr_o=1 whenever FIFO non-empty in CAPTURE/DRAIN; mcb_dat_o = FIFO head, mcb_adr_o = write address.
REQ-026 Transfer SHALL occur on a cycle with mcb_ce_o=1 and mcb_rdy_i=1: pop head, address+1 next cycle; dat/adr stable until accepted.
REQ-027 Push and pop in same cycle SHALL keep occupancy unchanged, also when full.
REQ-028 Address SHALL wrap 2^ABITS-1 -> 0; push count saturates and does not wrap.
REQ-029 FIFO latency: sample pushed at cycle n SHALL be presented on mcb_dat_o at cycle n+1 if FIFO was empty.
REQ-030 aq_delay_i and aq_debug_i changes SHALL take effect at the next strobe.

Reset
REQ-031 rst_i=1 SHALL force IDLE, empty FIFO, address 0, LFSR seed, history 0, all outputs 0, regardless of state or pending MCB request.
REQ-032 rst_i mid-transfer SHALL drop the pending write; mcb_ce_o=0 the following cycle.

Verification
REQ-033 ABITS=4: aq_ce_i=1, 16 strobes, mcb_rdy_i=1 -> 16 writes adr 0..15, DRAIN then DONE, aq_done_o=1; rd_req_i -> IDLE.
REQ-034 BBITS=2, mcb_rdy_i=0, 6 strobes -> 4 entries, aq_ovf_o=1, mcb_dat_o holds first sample unchanged.
REQ-035 aq_delay_i=5, ax_data_i=24'hA5A5A5 for one cycle then 0, strobe 5 cycles later -> ax_data_o=24'hA5A5A5; strobe at 4 or 6 -> 0.
REQ-036 aq_debug_i=1, first three strobes -> samples match LFSR reference model from seed 32'hACE1_0001.
REQ-037 aq_ce_i dropped with 3 FIFO entries, mcb_rdy_i toggling -> exactly 3 more writes, then DONE.
REQ-038 rst_i asserted in CAPTURE with mcb_ce_o=1 -> next cycle tart_state=0, all outputs 0.
